// File: rtl/mlp_ram_pkg.sv
// Shared types and elaboration helpers for the synchronous RAM and its read pipeline.
package mlp_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 3;

  function automatic int lanes_of(input int data_bits, input int lane_bits);
    return data_bits / lane_bits;
  endfunction

  function automatic bit read_latency_ok(input int read_latency);
    return (read_latency >= READ_LATENCY_MIN) && (read_latency <= READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/mlp_ram_rdpipe.sv
// Valid+data delay line; data stages only load on a valid beat so the output word holds between reads.
module mlp_ram_rdpipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/mlp_sync_ram.sv
// Single-port synchronous RAM with valid/ready requests, lane write enables,
// configurable read latency and a hardware clear sequence.
module mlp_sync_ram
  import mlp_ram_pkg::*;
#(
  parameter int ADDR_BITS      = 4,
  parameter int DATA_BITS      = 8,
  parameter int LANE_BITS      = 8,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       req_valid,
  output logic                                       req_ready,
  input  logic                                       req_write,
  input  logic [ADDR_BITS-1:0]                       req_addr,
  input  logic [DATA_BITS-1:0]                       req_wdata,
  input  logic [lanes_of(DATA_BITS, LANE_BITS)-1:0]  req_be,
  output logic                                       rsp_valid,
  output logic [DATA_BITS-1:0]                       rsp_rdata,
  input  logic                                       clear_req,
  output logic                                       busy
);

  localparam int LANES = lanes_of(DATA_BITS, LANE_BITS);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = '1;
  localparam ram_state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("mlp_sync_ram: READ_LATENCY must be within 1..3");
  end
  if ((DATA_BITS % LANE_BITS) != 0) begin : g_bad_lanes
    $error("mlp_sync_ram: DATA_BITS must be a multiple of LANE_BITS");
  end

  ram_state_e           state, state_n;
  logic [ADDR_BITS-1:0] clr_cnt, clr_cnt_n;
  logic                 clr_step;
  logic                 accept, wr_en, rd_en, clr_we;

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic                 cap_valid;
  logic [DATA_BITS-1:0] cap_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    clr_step  = 1'b0;
    req_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      CLEAR: begin
        busy     = 1'b1;
        clr_step = 1'b1;
        // Explicit last-address compare; never rely on the counter wrapping.
        if (clr_cnt == ADDR_LAST) begin
          state_n   = READY;
          clr_cnt_n = '0;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end
      READY: begin
        req_ready = reset_n;
        if (clear_req) state_n = CLEAR;
      end
      default: state_n = RESET_STATE;
    endcase
  end

  assign accept = req_valid && req_ready;
  assign wr_en  = accept && req_write;
  assign rd_en  = accept && !req_write;
  assign clr_we = clr_step && reset_n;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (req_be[i]) mem[req_addr][i*LANE_BITS +: LANE_BITS] <= req_wdata[i*LANE_BITS +: LANE_BITS];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else begin
      cap_valid <= rd_en;
      if (rd_en) cap_data <= mem[req_addr];
    end
  end

  if (READ_LATENCY > 1) begin : g_pipe
    mlp_ram_rdpipe #(
      .DEPTH (READ_LATENCY - 1),
      .WIDTH (DATA_BITS)
    ) u_rdpipe (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (cap_valid),
      .in_data   (cap_data),
      .out_valid (rsp_valid),
      .out_data  (rsp_rdata)
    );
  end else begin : g_nopipe
    assign rsp_valid = cap_valid;
    assign rsp_rdata = cap_data;
  end

endmodule

// File: tb/tb_mlp_sync_ram.sv
// Directed and randomized checks of mlp_sync_ram against a word-level reference model.
module tb_mlp_sync_ram;

  localparam int AB = 4;
  localparam int DB = 16;
  localparam int LB = 8;
  localparam int RL = 2;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AB-1:0] req_addr = '0;
  logic [DB-1:0] req_wdata = '0;
  logic [1:0]    req_be = '0;
  logic          clear_req = 1'b0;
  logic          req_ready, rsp_valid, busy;
  logic [DB-1:0] rsp_rdata;

  mlp_sync_ram #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .LANE_BITS(LB),
    .READ_LATENCY(RL), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .clear_req(clear_req), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DB-1:0] data;
  } rsp_t;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            busy_left = N;
  logic [DB-1:0] ref_mem [N];
  logic [DB-1:0] last_data = '0;
  rsp_t          q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check ready, let the edge happen, advance the model, check outputs.
  task automatic tick();
    logic          acc, w, clr;
    logic [AB-1:0] a;
    logic [DB-1:0] d;
    logic [1:0]    be;
    rsp_t          r;
    if (!reset_n) begin
      @(posedge clk); cyc++; #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      return;
    end
    chk("req_ready", 32'(req_ready), 32'(busy_left == 0));
    acc = req_valid && (busy_left == 0);
    w = req_write; a = req_addr; d = req_wdata; be = req_be; clr = clear_req;
    @(posedge clk); cyc++; #1;
    if (acc) begin
      if (w) begin
        for (int i = 0; i < 2; i++) if (be[i]) ref_mem[a][i*LB +: LB] = d[i*LB +: LB];
      end else begin
        r.due = cyc + RL - 1;
        r.data = ref_mem[a];
        q.push_back(r);
      end
    end
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) for (int i = 0; i < N; i++) ref_mem[i] = '0;
    end else if (clr) begin
      busy_left = N;
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_rdata", 32'(rsp_rdata), 32'(q[0].data));
      last_data = q[0].data;
      void'(q.pop_front());
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      chk("rsp_rdata_hold", 32'(rsp_rdata), 32'(last_data));
    end
    chk("busy", 32'(busy), 32'(busy_left > 0));
  endtask

  task automatic drive(input logic v, input logic w, input int a, input logic [DB-1:0] d,
                       input logic [1:0] be, input logic clr);
    req_valid = v; req_write = w; req_addr = AB'(a); req_wdata = d; req_be = be; clear_req = clr;
    tick();
    req_valid = 1'b0; req_write = 1'b0; clear_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd_expect(input string tag, input int a, input logic [DB-1:0] exp);
    drive(1'b1, 1'b0, a, '0, 2'b00, 1'b0);
    idle(RL - 1);
    chk(tag, 32'(rsp_rdata), 32'(exp));
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    q.delete();
    last_data = '0;
    busy_left = N;
    idle(n);
    reset_n = 1'b1;
    busy_left = N;
  endtask

  initial begin
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    #1;
    do_reset(3);

    // Power-up clear: busy for exactly 16 cycles.
    idle(N - 1);
    chk("busy_before_last_clear", 32'(busy), 32'd1);
    idle(1);
    chk("ready_after_clear", 32'(req_ready), 32'd1);
    for (int i = 0; i < N; i++) drive(1'b1, 1'b0, i, '0, 2'b00, 1'b0);
    idle(3);
    chk("cleared_word_15", 32'(rsp_rdata), 32'h0);

    // Latency and ordering.
    drive(1'b1, 1'b1, 3, 16'hA5A5, 2'b11, 1'b0);
    drive(1'b1, 1'b1, 4, 16'h1234, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 3, '0, 2'b00, 1'b0);
    chk("lat_not_yet", 32'(rsp_valid), 32'd0);
    drive(1'b1, 1'b0, 4, '0, 2'b00, 1'b0);
    chk("lat_first", 32'(rsp_rdata), 32'hA5A5);
    idle(1);
    chk("lat_second", 32'(rsp_rdata), 32'h1234);
    idle(2);

    // Byte enables.
    drive(1'b1, 1'b1, 7, 16'hFFFF, 2'b11, 1'b0);
    drive(1'b1, 1'b1, 7, 16'h0011, 2'b01, 1'b0);
    rd_expect("be_low_lane", 7, 16'hFF11);
    drive(1'b1, 1'b1, 7, 16'h1234, 2'b00, 1'b0);
    rd_expect("be_none", 7, 16'hFF11);

    // Read right after write.
    drive(1'b1, 1'b1, 9, 16'hBEEF, 2'b11, 1'b0);
    rd_expect("raw", 9, 16'hBEEF);

    // Clear command colliding with a read.
    drive(1'b1, 1'b1, 5, 16'h5555, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 5, '0, 2'b00, 1'b1);
    idle(1);
    chk("clear_collide_read", 32'(rsp_rdata), 32'h5555);
    idle(5);
    drive(1'b0, 1'b0, 0, '0, 2'b00, 1'b1);
    idle(8);
    chk("busy_last_clear_cycle", 32'(busy), 32'd1);
    idle(1);
    chk("busy_dropped", 32'(busy), 32'd0);
    rd_expect("after_clear", 5, 16'h0000);
    rd_expect("after_clear_9", 9, 16'h0000);

    // Randomized traffic with occasional clear commands.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_write = $urandom_range(0, 1) == 1;
      req_addr  = AB'($urandom_range(0, N - 1));
      req_wdata = DB'($urandom());
      req_be    = 2'($urandom_range(0, 3));
      clear_req = ($urandom_range(0, 59) == 0);
      tick();
    end
    req_valid = 1'b0; req_write = 1'b0; clear_req = 1'b0;
    idle(N + 4);

    // Reset in the middle of a commanded clear.
    drive(1'b1, 1'b1, 2, 16'hC0DE, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 2, '0, 2'b00, 1'b0);
    drive(1'b0, 1'b0, 0, '0, 2'b00, 1'b1);
    idle(6);
    do_reset(3);
    idle(N - 1);
    chk("restart_busy_full", 32'(busy), 32'd1);
    idle(1);
    chk("restart_ready", 32'(req_ready), 32'd1);
    rd_expect("restart_clear_2", 2, 16'h0000);
    rd_expect("restart_clear_15", 15, 16'h0000);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
